// File: rtl/frame_round_robin_scheduler_pkg.sv
// Shared types and constants for the frame-atomic round-robin scheduler.
// The width helpers keep the sub-module and the top consistent for any channel count.
package frame_round_robin_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_XFER   = 2'd2,
      ST_ABORT  = 2'd3
   } state_e;

   localparam logic [15:0] ABORT_MARKER = 16'hDEAD;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // CHAN_W
   function automatic int chan_w(input int n_chan);
      return clog2_min1(n_chan);
   endfunction

   // CNT_W: must be able to hold FRAME_WORDS itself
   function automatic int cnt_w(input int frame_words);
      return $clog2(frame_words + 1);
   endfunction

endpackage

// File: rtl/frame_round_robin_scheduler_rr_pick.sv
// Combinational round-robin pick: first requester after last_i, wrapping,
// with last_i itself considered last.
module frame_round_robin_scheduler_rr_pick
   import frame_round_robin_scheduler_pkg::*;
#(
   parameter int N = 4,
   parameter int W = chan_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] idx_o,
   output logic         vld_o
);

   logic [W-1:0] cand;

   // Scan farthest-to-nearest so the nearest requester is the final assignment.
   always_comb begin
      idx_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int i = N; i >= 1; i--) begin
         cand = W'((int'(last_i) + i) % N);
         if (req_i[cand]) begin
            vld_o = 1'b1;
            idx_o = cand;
         end
      end
   end

endmodule

// File: rtl/frame_round_robin_scheduler.sv
// Frame-atomic round-robin drain of per-channel standard-read FIFOs into one
// output FIFO, with mid-frame starvation abort and a completed-frame counter.
module frame_round_robin_scheduler
   import frame_round_robin_scheduler_pkg::*;
#(
   parameter int ADC_CHANEL  = 4,
   parameter int FRAME_WORDS = 1026,
   parameter int TIMEOUT     = 1024
) (
   input  logic                            clk_100m,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            clear_err,
   input  logic [ADC_CHANEL-1:0]           fifo_empty,
   input  logic [32*ADC_CHANEL-1:0]        fifo_dout,
   output logic [ADC_CHANEL-1:0]           fifo_rden,
   input  logic                            out_almost_full,
   output logic                            out_wren,
   output logic [31:0]                     out_data,
   output logic                            busy,
   output logic [chan_w(ADC_CHANEL)-1:0]   cur_chan,
   output logic [31:0]                     frame_cnt,
   output logic [ADC_CHANEL-1:0]           timeout_err
);

   localparam int CHAN_W  = chan_w(ADC_CHANEL);
   localparam int CNT_W   = cnt_w(FRAME_WORDS);
   localparam int STALL_W = clog2_min1(TIMEOUT);

   localparam logic [CNT_W-1:0]   FRAME_LEN = CNT_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic [CHAN_W-1:0]   grant_q, grant_d;
   logic [CHAN_W-1:0]   last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
   logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [ADC_CHANEL-1:0] err_q, err_d;
   logic [31:0]         frame_cnt_q, frame_cnt_d;

   logic                wren_q;
   logic                marker_q;
   logic [31:0]         marker_data_q;
   logic [CHAN_W-1:0]   grant_dly_q;
   logic                last_dly_q;

   logic [ADC_CHANEL-1:0] req;
   logic [CHAN_W-1:0]   pick_idx;
   logic                pick_vld;
   logic                grant_empty;
   logic                rd_ok;
   logic                rd_last;
   logic                marker_go;
   logic [31:0]         marker_word;

   assign req = ~fifo_empty;

   frame_round_robin_scheduler_rr_pick #(
      .N (ADC_CHANEL),
      .W (CHAN_W)
   ) u_rr_pick (
      .req_i  (req),
      .last_i (last_grant_q),
      .idx_o  (pick_idx),
      .vld_o  (pick_vld)
   );

   assign grant_empty = fifo_empty[grant_q];
   assign rd_ok       = (state_q == ST_XFER) && !grant_empty && !out_almost_full
                        && (word_cnt_q < FRAME_LEN);
   assign rd_last     = rd_ok && (word_cnt_q == LAST_IDX);
   assign marker_go   = (state_q == ST_ABORT) && !out_almost_full;
   assign marker_word = {ABORT_MARKER, 4'(grant_q), 12'(word_cnt_q)};

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      word_cnt_d   = word_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      err_d        = err_q;
      frame_cnt_d  = frame_cnt_q;
      fifo_rden    = '0;

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (pick_vld) begin
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               word_cnt_d   = '0;
               stall_cnt_d  = '0;
               state_d      = ST_XFER;
            end
         end
         ST_XFER: begin
            // Backpressure holds the stall counter; only source starvation advances it.
            if (rd_ok) begin
               fifo_rden[grant_q] = 1'b1;
               word_cnt_d         = word_cnt_q + 1'b1;
               stall_cnt_d        = '0;
               if (rd_last) state_d = ST_SELECT;
            end else if (grant_empty) begin
               if (stall_cnt_q == STALL_MAX) state_d = ST_ABORT;
               else                          stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         ST_ABORT: begin
            if (!out_almost_full) state_d = ST_SELECT;
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear_err) err_d = '0;
      if (marker_go) err_d[grant_q] = 1'b1;
      if (wren_q && last_dly_q) frame_cnt_d = frame_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_100m or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         last_grant_q  <= CHAN_W'(ADC_CHANEL - 1);
         word_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         err_q         <= '0;
         frame_cnt_q   <= '0;
         wren_q        <= 1'b0;
         marker_q      <= 1'b0;
         marker_data_q <= '0;
         grant_dly_q   <= '0;
         last_dly_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_grant_q  <= last_grant_d;
         word_cnt_q    <= word_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         err_q         <= err_d;
         frame_cnt_q   <= frame_cnt_d;
         wren_q        <= rd_ok | marker_go;
         marker_q      <= marker_go;
         marker_data_q <= marker_word;
         grant_dly_q   <= grant_q;
         last_dly_q    <= rd_last;
      end
   end

   // Source data arrives one cycle after rden, aligned with wren_q.
   always_comb begin
      out_data = '0;
      if (wren_q) begin
         if (marker_q) out_data = marker_data_q;
         else          out_data = fifo_dout[int'(grant_dly_q)*32 +: 32];
      end
   end

   assign out_wren    = wren_q;
   assign busy        = (state_q != ST_IDLE);
   assign cur_chan    = grant_q;
   assign frame_cnt   = frame_cnt_q;
   assign timeout_err = err_q;

endmodule
